inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch front end: the producer side of the decode stage's instruction interface. It keeps the fetch PC and issues in-order requests to instruction memory. Returned 32-bit words are buffered in a small FIFO, zero-extended, and presented to decode with their PC over a valid/ready handshake. A redirect from execute flushes the queue and discards stale in-flight responses.

## Interface
- PC_W, 64, fetch/redirect address width
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- DEPTH, 2, FIFO entries and maximum outstanding-plus-buffered credit; power of two, ≥2
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- redirect  in  1  flush pulse from execute/branch unit
- redirect_pc  in  PC_W  new fetch address, sampled when redirect=1
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  request address (fetch_pc)
- imem_resp_valid  in  1  one response word, strictly in request order
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts
- inst  out  64  {32'b0, word}
- inst_pc  out  PC_W  PC of inst
- fetch_fault  out  1  present only with FETCH_MISALIGN_CHECK_EN

## Operation
- Registers: fetch_pc, resp_pc (PC of next kept response), outstanding (0..DEPTH), drop_cnt (0..DEPTH), FIFO of {word, pc}.
- Credit rule: imem_req_valid = (outstanding + fifo_count < DEPTH); never depends on redirect or imem_req_ready combinationally.
- Request accepted (valid&&ready): fetch_pc += 4 (mod 2^PC_W wrap), outstanding++.
- Response: outstanding--. If drop_cnt>0: discard, drop_cnt--. Else push {data, resp_pc}, resp_pc += 4.
- Pop on inst_valid&&inst_ready. Push and pop in same cycle legal at any count.
- State: RUN (drop_cnt==0) / DRAIN (drop_cnt>0). Requests continue issuing in DRAIN; only the response path differs.
- Redirect (highest priority): FIFO cleared; fetch_pc and resp_pc <= redirect_pc; drop_cnt <= outstanding after this cycle's request/response accounting (a request accepted in the redirect cycle is stale and counted; a response arriving that cycle is dropped). An entry handshaked with decode that cycle is discarded.
- Memory never returns a response without a matching outstanding request. A response with outstanding==0 is a protocol error: it is ignored and not pushed.

## Timing
- Reset values: fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, inst_valid=0, inst=0, inst_pc=0, imem_req_valid=1 once out of reset, fetch_fault=0.
- Reset asserted mid-operation: all state returns to reset values immediately. Responses to pre-reset requests are the memory's responsibility to squash.
- Response captured at edge N: inst_valid=1 from cycle N+1 (one-cycle latency, registered FIFO output).
- Redirect at cycle t: inst_valid=0 in t+1; request for redirect_pc presented in t+1 if credit allows.
- Credit freed by pop or response at edge N is usable for a request in cycle N+1.
- FIFO full: with outstanding=0 and fifo_count=DEPTH, imem_req_valid=0 and no overflow is possible by construction.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: a redirect_pc with bits [1:0]≠0 sets fetch_fault (sticky until next redirect or reset). Requests are suppressed while fault is set. fetch_pc is still loaded.
- Undefined: no fetch_fault port; bits [1:0] of redirect_pc are forced to 0.

## Structure
- Shared package: PC_W, RESET_PC, INST_BYTES=4, and the fetch entry struct {word[31:0], pc}.
- One sub-module: fetch_fifo (parameterised DEPTH, synchronous clear, push/pop/count/full/empty).

## Test plan
- Reset release, imem_req_ready=1, one-cycle memory: addresses 0x8000_0000, 0x8000_0004 issued; inst_pc sequence matches; inst upper 32 bits = 0.
- inst_ready=0 for 10 cycles: at most DEPTH requests accepted, imem_req_valid=0 afterward, no entry lost once ready=1.
- Redirect to 0x8000_0100 with 2 responses outstanding: both dropped (DRAIN), first delivered inst_pc=0x8000_0100.
- Redirect coinciding with request accept, response arrival, and decode pop: all three discarded; next inst_pc=redirect_pc.
- fetch_pc at 0xFFFF_FFFF_FFFF_FFFC: next request wraps to 0.
- With FETCH_MISALIGN_CHECK_EN: redirect_pc=0x8000_0002 -> fetch_fault=1, no requests; redirect to 0x8000_0008 clears the fault.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: address width, reset PC, instruction size
// and the FIFO entry layout.
package inst_fetch_pkg;

  localparam int unsigned PC_W       = 64;
  localparam logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [31:0]     word;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small power-of-two FIFO for fetched words; synchronous clear overrides
// push/pop, head is read straight from the storage registers.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = $bits(fetch_entry_t)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wr] <= i_push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: credit-limited in-order requests, response
// FIFO to decode, redirect flush with stale-response drain.
// Optional: FETCH_MISALIGN_CHECK_EN adds the sticky fetch_fault output.
module inst_fetch #(
  parameter int unsigned          PC_W     = inst_fetch_pkg::PC_W,
  parameter logic [PC_W-1:0]      RESET_PC = inst_fetch_pkg::RESET_PC,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [63:0]     inst,
  output logic [PC_W-1:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  import inst_fetch_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  fetch_state_e    r_state;

  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_drop_next;
  fetch_state_e    w_state_next;
  logic [CW-1:0]   w_fifo_count;
  logic [PC_W-1:0] w_redir_pc;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_resp_ok;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < CREDIT_MAX;
  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_resp_ok  = imem_resp_valid && (r_outstanding != '0);
  assign w_pop      = inst_valid && inst_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;
  assign w_redir_pc     = redirect_pc;
  assign imem_req_valid = w_credit && !r_fault;
  assign fetch_fault    = r_fault;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        r_fault <= 1'b0;
    else if (redirect) r_fault <= (redirect_pc[1:0] != 2'b00);
  end
`else
  assign w_redir_pc     = redirect_pc & ~PC_W'(3);
  assign imem_req_valid = w_credit;
`endif

  assign imem_req_addr = r_fetch_pc;

  // Redirect sees this cycle's accept/response already accounted, so every
  // request still in flight afterwards is stale and must be dropped.
  always_comb begin
    w_out_next   = r_outstanding + CW'(w_req_fire) - CW'(w_resp_ok);
    w_drop_next  = r_drop_cnt;
    w_push       = 1'b0;
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   w_push = w_resp_ok;
      ST_DRAIN: if (w_resp_ok) w_drop_next = r_drop_cnt - CW'(1);
      default:  w_push = 1'b0;
    endcase
    if (redirect) begin
      w_push      = 1'b0;
      w_drop_next = w_out_next;
    end
    w_state_next = (w_drop_next != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_RUN;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_drop_next;
      if (redirect) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_W'(INST_BYTES);
        if (w_push)     r_resp_pc  <= r_resp_pc + PC_W'(INST_BYTES);
      end
    end
  end

  assign w_push_entry.word = imem_resp_data;
  assign w_push_entry.pc   = r_resp_pc;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_clr       (redirect),
    .i_push      (w_push && !w_full),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign inst_valid = !w_empty;
  assign inst       = inst_valid ? {32'b0, w_head.word} : '0;
  assign inst_pc    = inst_valid ? w_head.pc : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: an in-order memory, a queue-based fetch
// model and directed scenarios pinned by literal expectations.
module tb_inst_fetch;

  localparam int unsigned TB_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst;
  logic [63:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  inst_fetch #(.DEPTH(TB_DEPTH)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault     (fetch_fault)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [63:0] pc; logic stale; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] w; } ent_t;

  req_t        m_pend[$];
  ent_t        m_fifo[$];
  logic [63:0] m_fetch_pc;
  logic        m_fault;
  logic [63:0] mem_q[$];
  logic [63:0] issued_q[$];
  logic [63:0] deliv_q[$];

  int unsigned rdy_rate, mem_rate, dec_rate, redir_rate;
  logic        force_redir, bogus;
  logic [63:0] force_pc;
  logic        last_fire, last_resp, last_pop;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    p = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 : 64'h0000_0000_8000_0000;
    p = p + 64'($urandom_range(0, 255));
    if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
    return p;
  endfunction

  function automatic logic m_req_valid();
    return (m_pend.size() + m_fifo.size() < TB_DEPTH) && !m_fault;
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_fifo.delete();
    mem_q.delete();
    m_fetch_pc = 64'h0000_0000_8000_0000;
    m_fault    = 1'b0;
  endtask

  task automatic model_step(input logic fire, input logic resp, input logic [31:0] d,
                            input logic pop, input logic redir, input logic [63:0] rpc);
    req_t r;
    if (pop) void'(m_fifo.pop_front());
    if (resp && m_pend.size() != 0) begin
      r = m_pend.pop_front();
      if (!r.stale) m_fifo.push_back('{pc: r.pc, w: d});
    end
    if (fire) begin
      m_pend.push_back('{pc: m_fetch_pc, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 64'd4;
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_pend[i]) m_pend[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      m_fetch_pc = rpc;
      m_fault    = (rpc[1:0] != 2'b00);
`else
      m_fetch_pc = {rpc[63:2], 2'b00};
`endif
    end
  endtask

  task automatic check_outputs();
    chk("inst_valid", inst_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) begin
      chk("inst", inst, {32'b0, m_fifo[0].w});
      chk("inst_pc", inst_pc, m_fifo[0].pc);
    end
    chk("req_valid", imem_req_valid, m_req_valid());
    if (m_req_valid()) chk("req_addr", imem_req_addr, m_fetch_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("fetch_fault", fetch_fault, m_fault);
`endif
  endtask

  // One clock: check at the falling edge, drive, then advance memory and model.
  task automatic cycle();
    logic fire_d, fire_m, pop_m, pop_d, resp, redir;
    logic [63:0] addr_d, rpc;
    logic [31:0] rdata;
    check_outputs();
    imem_req_ready = ($urandom_range(0, 99) < rdy_rate);
    inst_ready     = ($urandom_range(0, 99) < dec_rate);
    if (bogus) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
    end else if (mem_q.size() != 0 && $urandom_range(0, 99) < mem_rate) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    redir       = force_redir || ($urandom_range(0, 999) < redir_rate);
    rpc         = force_redir ? force_pc : rand_pc();
    redirect    = redir;
    redirect_pc = rpc;
    resp   = imem_resp_valid;
    rdata  = imem_resp_data;
    fire_d = imem_req_valid && imem_req_ready;
    addr_d = imem_req_addr;
    fire_m = m_req_valid() && imem_req_ready;
    pop_m  = (m_fifo.size() != 0) && inst_ready;
    pop_d  = inst_valid && inst_ready;
    last_fire = fire_d; last_resp = resp; last_pop = pop_d;
    if (fire_d) issued_q.push_back(addr_d);
    if (pop_d)  deliv_q.push_back(inst_pc);
    @(posedge CLK);
    if (resp && mem_q.size() != 0) void'(mem_q.pop_front());
    if (fire_d) mem_q.push_back(addr_d);
    model_step(fire_m, resp, rdata, pop_m, redir, rpc);
    @(negedge CLK);
    redirect        = 1'b0;
    imem_resp_valid = 1'b0;
  endtask

  task automatic set_rates(input int unsigned r, input int unsigned m, input int unsigned d);
    rdy_rate = r; mem_rate = m; dec_rate = d;
  endtask

  task automatic drain();
    set_rates(0, 100, 100);
    for (int i = 0; i < 40 && (mem_q.size() != 0 || m_fifo.size() != 0); i++) cycle();
    chk("drain_done", (mem_q.size() == 0) && (m_fifo.size() == 0), 1'b1);
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    force_redir = 1'b1;
    force_pc    = pc;
    cycle();
    force_redir = 1'b0;
  endtask

  task automatic wait_first_deliv(input string nm, input logic [63:0] exp);
    for (int i = 0; i < 40 && deliv_q.size() == 0; i++) cycle();
    chk(nm, (deliv_q.size() != 0) ? deliv_q[0] : 64'hDEAD_DEAD_DEAD_DEAD, exp);
  endtask

  initial begin
    RST_N = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
    force_redir = 1'b0; bogus = 1'b0; force_pc = '0; redir_rate = 0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_req_valid", imem_req_valid, 1'b1);
    chk("rst_req_addr", imem_req_addr, 64'h0000_0000_8000_0000);

    set_rates(100, 100, 100);
    repeat (8) cycle();
    chk("boot_addr0", (issued_q.size() > 0) ? issued_q[0] : '1, 64'h8000_0000);
    chk("boot_addr1", (issued_q.size() > 1) ? issued_q[1] : '1, 64'h8000_0004);
    chk("boot_pc0", (deliv_q.size() > 0) ? deliv_q[0] : '1, 64'h8000_0000);
    chk("boot_pc1", (deliv_q.size() > 1) ? deliv_q[1] : '1, 64'h8000_0004);

    issued_q.delete();
    set_rates(100, 100, 0);
    repeat (10) cycle();
    chk("stall_accepts", issued_q.size() <= TB_DEPTH, 1'b1);
    chk("stall_req_valid", imem_req_valid, 1'b0);
    chk("stall_inst_valid", inst_valid, 1'b1);
    set_rates(100, 100, 100);
    repeat (10) cycle();

    drain();
    set_rates(100, 0, 100);
    repeat (2) cycle();
    chk("pre_redir_outstanding", mem_q.size(), 2);
    set_rates(0, 0, 100);
    do_redirect(64'h0000_0000_8000_0100);
    deliv_q.delete();
    chk("redir_inst_valid", inst_valid, 1'b0);
    set_rates(100, 100, 100);
    wait_first_deliv("redir_first_pc", 64'h8000_0100);

    drain();
    set_rates(100, 0, 0);   cycle();
    set_rates(0, 100, 0);   cycle();
    set_rates(100, 0, 0);   cycle();
    set_rates(100, 100, 100);
    do_redirect(64'h0000_0000_8000_0200);
    chk("coinc_fire_resp_pop", {last_fire, last_resp, last_pop}, 3'b111);
    chk("coinc_inst_valid", inst_valid, 1'b0);
    deliv_q.delete();
    wait_first_deliv("coinc_first_pc", 64'h8000_0200);

    drain();
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    issued_q.delete();
    set_rates(100, 100, 100);
    repeat (4) cycle();
    chk("wrap_addr0", (issued_q.size() > 0) ? issued_q[0] : '1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr1", (issued_q.size() > 1) ? issued_q[1] : '1, 64'h0);

    drain();
    bogus = 1'b1;
    cycle();
    bogus = 1'b0;
    cycle();
    chk("bogus_inst_valid", inst_valid, 1'b0);
    chk("bogus_req_valid", imem_req_valid, 1'b1);

`ifdef FETCH_MISALIGN_CHECK_EN
    drain();
    do_redirect(64'h0000_0000_8000_0002);
    chk("misalign_fault", fetch_fault, 1'b1);
    chk("misalign_no_req", imem_req_valid, 1'b0);
    set_rates(100, 100, 100);
    repeat (3) cycle();
    do_redirect(64'h0000_0000_8000_0008);
    chk("misalign_clear", fetch_fault, 1'b0);
`endif

    set_rates(100, 60, 70);
    repeat (6) cycle();
    RST_N = 1'b0;
    #1;
    chk("async_rst_inst_valid", inst_valid, 1'b0);
    chk("async_rst_req_addr", imem_req_addr, 64'h0000_0000_8000_0000);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;

    for (int blk = 0; blk < 30; blk++) begin
      set_rates($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100));
      redir_rate = $urandom_range(0, 40);
      repeat (100) cycle();
    end
    redir_rate = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
